// File: rtl/display_scan_ctrl.sv
// Time-multiplexed scan controller: shares one 2-digit decoder across four display fields.
// Optional blinking of masked slots is built only when DISP_BLINK_EN is defined.
module display_scan_ctrl #(
  parameter int unsigned PRESCALE     = 8,
  parameter int unsigned BLANK_CYC    = 2,
  parameter int unsigned BLINK_FRAMES = 4
) (
  input  logic       Clk,
  input  logic       Reset_n,
  input  logic       Enable,
  input  logic [6:0] Field0,
  input  logic [6:0] Field1,
  input  logic [6:0] Field2,
  input  logic [6:0] Field3,
  input  logic [3:0] Blink_mask,
  input  logic [6:0] Seg_in1,
  input  logic [6:0] Seg_in0,
  output logic [6:0] Bin_out,
  output logic [6:0] Seg_out1,
  output logic [6:0] Seg_out0,
  output logic [3:0] Sel,
  output logic       Frame_start
);

  localparam int unsigned   CW         = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [CW-1:0] CNT_LAST   = CW'(PRESCALE - 1);
  localparam logic [CW-1:0] BLANK_LAST = CW'(BLANK_CYC - 1);

  typedef enum logic [1:0] {IDLE, BLANK, DRIVE} state_e;

  state_e          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [1:0]      slot_q, slot_d;
  logic [3:0][6:0] shadow_q, shadow_d;
  logic [6:0]      bin_q, bin_d;
  logic [3:0]      sel_q, sel_d;
  logic            fs_q, fs_d;
  logic [6:0]      seg1_q, seg0_q;
  logic [3:0][6:0] fields;
  logic            frame_wrap;
  logic            blink_off;

  assign fields     = {Field3, Field2, Field1, Field0};
  assign frame_wrap = Enable && (state_q == DRIVE) && (cnt_q == CNT_LAST) && (slot_q == 2'd3);

`ifdef DISP_BLINK_EN
  localparam int unsigned BW = $clog2(BLINK_FRAMES + 1);

  logic [BW-1:0] bcnt_q, bcnt_d;
  logic          phase_q, phase_d;
  logic [3:0]    mask_q, mask_d;

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      bcnt_q  <= '0;
      phase_q <= 1'b0;
      mask_q  <= '0;
    end else begin
      bcnt_q  <= bcnt_d;
      phase_q <= phase_d;
      mask_q  <= mask_d;
    end
  end

  always_comb begin
    bcnt_d  = bcnt_q;
    phase_d = phase_q;
    mask_d  = mask_q;
    if (!Enable) begin
      bcnt_d  = '0;
      phase_d = 1'b0;
    end else if (state_q == IDLE) begin
      mask_d = Blink_mask;
    end else if (frame_wrap) begin
      mask_d = Blink_mask;
      if (bcnt_q == BW'(BLINK_FRAMES - 1)) begin
        bcnt_d  = '0;
        phase_d = ~phase_q;
      end else begin
        bcnt_d = bcnt_q + 1'b1;
      end
    end
  end

  assign blink_off = phase_q & mask_q[slot_q];
`else
  logic [4:0] unused_blink;
  assign unused_blink = {Blink_mask, BLINK_FRAMES[0]};
  assign blink_off    = 1'b0;
`endif

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      slot_q   <= '0;
      shadow_q <= '0;
      bin_q    <= '0;
      sel_q    <= '0;
      fs_q     <= 1'b0;
      seg1_q   <= '0;
      seg0_q   <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      slot_q   <= slot_d;
      shadow_q <= shadow_d;
      bin_q    <= bin_d;
      sel_q    <= sel_d;
      fs_q     <= fs_d;
      seg1_q   <= Seg_in1;
      seg0_q   <= Seg_in0;
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    slot_d   = slot_q;
    shadow_d = shadow_q;
    bin_d    = bin_q;
    fs_d     = 1'b0;
    if (!Enable) begin
      state_d = IDLE;
      cnt_d   = '0;
      slot_d  = '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          state_d  = BLANK;
          cnt_d    = '0;
          slot_d   = '0;
          shadow_d = fields;
          bin_d    = Field0;
          fs_d     = 1'b1;
        end
        BLANK: begin
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == BLANK_LAST) state_d = DRIVE;
        end
        DRIVE: begin
          if (cnt_q == CNT_LAST) begin
            state_d = BLANK;
            cnt_d   = '0;
            slot_d  = slot_q + 1'b1;
            if (frame_wrap) begin
              shadow_d = fields;
              bin_d    = Field0;
              fs_d     = 1'b1;
            end else begin
              bin_d = shadow_q[slot_d];
            end
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // Sel trails the state by one edge so it lines up with the registered segment patterns.
  always_comb begin
    sel_d = '0;
    if (Enable && (state_q == DRIVE) && (shadow_q[slot_q] <= 7'd99) && !blink_off)
      sel_d = 4'b0001 << slot_q;
  end

  assign Bin_out     = bin_q;
  assign Sel         = sel_q;
  assign Frame_start = fs_q;
  assign Seg_out1    = seg1_q;
  assign Seg_out0    = seg0_q;

endmodule

// File: tb/tb_display_scan_ctrl.sv
// Self-checking bench for display_scan_ctrl: directed vector table, hand sequences,
// and randomized stimulus against a frame-arithmetic reference model.
module tb_display_scan_ctrl;

  localparam int P  = 8;
  localparam int B  = 2;
  localparam int BF = 2;

  logic       Clk = 1'b0;
  logic       Reset_n = 1'b0;
  logic       Enable = 1'b0;
  logic [6:0] Field0 = 7'd12, Field1 = 7'd34, Field2 = 7'd56, Field3 = 7'd7;
  logic [3:0] Blink_mask = 4'b0000;
  logic [6:0] Seg_in1, Seg_in0;
  logic [6:0] Bin_out, Seg_out1, Seg_out0;
  logic [3:0] Sel;
  logic       Frame_start;

  int vectors = 0;
  int miscompares = 0;
  bit chk_en = 1'b0;

  display_scan_ctrl #(.PRESCALE(P), .BLANK_CYC(B), .BLINK_FRAMES(BF)) dut (
    .Clk(Clk), .Reset_n(Reset_n), .Enable(Enable),
    .Field0(Field0), .Field1(Field1), .Field2(Field2), .Field3(Field3),
    .Blink_mask(Blink_mask), .Seg_in1(Seg_in1), .Seg_in0(Seg_in0),
    .Bin_out(Bin_out), .Seg_out1(Seg_out1), .Seg_out0(Seg_out0),
    .Sel(Sel), .Frame_start(Frame_start)
  );

  always #5 Clk = ~Clk;

  // Segment order abcdefg, a = bit 6.
  function automatic logic [6:0] dig(input int d);
    case (d)
      0: return 7'h7E; 1: return 7'h30; 2: return 7'h6D; 3: return 7'h79;
      4: return 7'h33; 5: return 7'h5B; 6: return 7'h5F; 7: return 7'h70;
      8: return 7'h7F; 9: return 7'h7B;
      default: return 7'h00;
    endcase
  endfunction

  always_comb begin
    Seg_in1 = dig(int'(Bin_out) / 10);
    Seg_in0 = dig(int'(Bin_out) % 10);
  end

  // Reference model: position within the scan is derived from k, the edge count since enable.
  bit         m_run;
  int         m_k;
  int         m_snap[4];
  logic [3:0] m_mask;
  logic [6:0] m_bin, m_s1, m_s0;
  logic [3:0] m_sel;
  logic       m_fs;
  int         m_slot;
  bit         m_lit;

  always @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      m_run = 0; m_k = 0; m_bin = 0; m_sel = 0; m_fs = 0; m_s1 = 0; m_s0 = 0;
    end else begin
      m_s1 = dig(int'(m_bin) / 10);
      m_s0 = dig(int'(m_bin) % 10);
      if (!Enable) begin
        m_run = 0; m_sel = 0; m_fs = 0;
      end else if (!m_run) begin
        m_run = 1; m_k = 0;
        m_snap[0] = Field0; m_snap[1] = Field1; m_snap[2] = Field2; m_snap[3] = Field3;
        m_mask = Blink_mask;
        m_bin = m_snap[0]; m_fs = 1; m_sel = 0;
      end else begin
        m_slot = (m_k / P) % 4;
        m_lit  = ((m_k % P) >= B) && (m_snap[m_slot] <= 99);
`ifdef DISP_BLINK_EN
        if ((((m_k / (4 * P)) / BF) % 2 == 1) && m_mask[m_slot]) m_lit = 0;
`endif
        m_sel = m_lit ? (4'b0001 << m_slot) : 4'b0000;
        m_k++;
        m_fs = (m_k % (4 * P) == 0);
        if (m_fs) begin
          m_snap[0] = Field0; m_snap[1] = Field1; m_snap[2] = Field2; m_snap[3] = Field3;
          m_mask = Blink_mask;
        end
        m_bin = 7'(m_snap[(m_k / P) % 4]);
      end
    end
  end

  always @(negedge Clk) begin
    if (chk_en) begin
      vectors++;
      if ({Bin_out, Sel, Frame_start, Seg_out1, Seg_out0} !== {m_bin, m_sel, m_fs, m_s1, m_s0}) begin
        miscompares++;
        $display("FAIL model t=%0t: bin=%0d sel=%b fs=%b seg=%h/%h, expected bin=%0d sel=%b fs=%b seg=%h/%h",
                 $time, Bin_out, Sel, Frame_start, Seg_out1, Seg_out0, m_bin, m_sel, m_fs, m_s1, m_s0);
      end
    end
  end

  task automatic check(input string name, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  typedef struct {
    int         edge_n;
    logic [6:0] bin;
    logic [3:0] sel;
    logic       fs;
    logic [6:0] s1;
    logic [6:0] s0;
  } vec_t;

  vec_t tbl[12];
  int   c0, c1, c2, c3, nfs;
  bit   found;

  initial begin
    tbl[0]  = '{0,  7'd12, 4'b0000, 1'b1, 7'h7E, 7'h7E};
    tbl[1]  = '{1,  7'd12, 4'b0000, 1'b0, 7'h30, 7'h6D};
    tbl[2]  = '{2,  7'd12, 4'b0000, 1'b0, 7'h30, 7'h6D};
    tbl[3]  = '{3,  7'd12, 4'b0001, 1'b0, 7'h30, 7'h6D};
    tbl[4]  = '{8,  7'd34, 4'b0001, 1'b0, 7'h30, 7'h6D};
    tbl[5]  = '{9,  7'd34, 4'b0000, 1'b0, 7'h79, 7'h33};
    tbl[6]  = '{11, 7'd34, 4'b0010, 1'b0, 7'h79, 7'h33};
    tbl[7]  = '{16, 7'd56, 4'b0010, 1'b0, 7'h79, 7'h33};
    tbl[8]  = '{19, 7'd56, 4'b0100, 1'b0, 7'h5B, 7'h5F};
    tbl[9]  = '{27, 7'd7,  4'b1000, 1'b0, 7'h7E, 7'h70};
    tbl[10] = '{32, 7'd12, 4'b1000, 1'b1, 7'h7E, 7'h70};
    tbl[11] = '{33, 7'd12, 4'b0000, 1'b0, 7'h30, 7'h6D};

    @(negedge Clk);
    chk_en = 1'b1;
    @(negedge Clk);
    Reset_n = 1'b1;
    #1;
    check("reset_bin", Bin_out, 0);
    check("reset_sel", Sel, 0);
    check("reset_fs", Frame_start, 0);
    check("reset_seg", {Seg_out1, Seg_out0}, 0);
    @(negedge Clk);

    // First frame against the vector table; edge 0 samples Enable.
    Enable = 1'b1;
    for (int e = 0, t = 0; e <= 33; e++) begin
      @(negedge Clk);
      if (t < 12 && tbl[t].edge_n == e) begin
        check($sformatf("tbl%0d_bin", t), Bin_out, tbl[t].bin);
        check($sformatf("tbl%0d_sel", t), Sel, tbl[t].sel);
        check($sformatf("tbl%0d_fs", t), Frame_start, tbl[t].fs);
        check($sformatf("tbl%0d_seg", t), {Seg_out1, Seg_out0}, {tbl[t].s1, tbl[t].s0});
        t++;
      end
    end

    // Field change mid-slot does not tear the current frame.
    repeat (11) @(negedge Clk);
    Field1 = 7'd99;
    @(negedge Clk);
    check("frozen_slot1", Bin_out, 34);
    nfs = 0;
    for (int e = 46; e <= 109; e++) begin
      @(negedge Clk);
      nfs += int'(Frame_start);
      if (e == 72) check("next_frame_slot1", Bin_out, 99);
    end
    check("fs_per_64", nfs, 2);

    // Out-of-range field suppresses only its own slot.
    Field2 = 7'd120;
    repeat (19) @(negedge Clk);
    c1 = 0; c2 = 0; c3 = 0;
    repeat (32) begin
      @(negedge Clk);
      c1 += int'(Sel[1]); c2 += int'(Sel[2]); c3 += int'(Sel[3]);
    end
    check("suppr_slot2", c2, 0);
    check("suppr_slot1_ok", c1, P - B);
    check("suppr_slot3_ok", c3, P - B);
    Field2 = 7'd56;

    // Enable dropped during slot 2 drive, then restart with blink mask.
    found = 0;
    for (int i = 0; i < 100 && !found; i++) begin
      @(negedge Clk);
      found = Sel[2];
    end
    check("wait_slot2", int'(found), 1);
    Enable = 1'b0;
    @(negedge Clk);
    check("disable_sel", Sel, 0);
    @(negedge Clk);
    Blink_mask = 4'b0100;
    Enable = 1'b1;
    @(negedge Clk);
    check("reenable_fs", Frame_start, 1);
    check("reenable_bin", Bin_out, 12);
    for (int f = 0; f < 6; f++) begin
      c0 = 0; c2 = 0;
      repeat (32) begin
        @(negedge Clk);
        c0 += int'(Sel[0]); c2 += int'(Sel[2]);
      end
      check($sformatf("blink_f%0d_slot0", f), c0, P - B);
`ifdef DISP_BLINK_EN
      check($sformatf("blink_f%0d_slot2", f), c2, ((f / BF) % 2 == 1) ? 0 : P - B);
`else
      check($sformatf("blink_f%0d_slot2", f), c2, P - B);
`endif
    end

    // Asynchronous reset mid-drive.
    found = 0;
    for (int i = 0; i < 40 && !found; i++) begin
      @(negedge Clk);
      found = (Sel != 0);
    end
    check("wait_drive", int'(found), 1);
    #2 Reset_n = 1'b0;
    #1;
    check("async_rst_outs", {Bin_out, Sel, Frame_start, Seg_out1, Seg_out0}, 0);
    @(negedge Clk);
    Reset_n = 1'b1;

    // Randomized operation checked by the reference model.
    for (int i = 0; i < 3000; i++) begin
      @(negedge Clk);
      if (Enable) begin
        if ($urandom_range(0, 59) == 0) Enable = 1'b0;
      end else if ($urandom_range(0, 3) == 0) Enable = 1'b1;
      if ($urandom_range(0, 9) == 0) Field0 = 7'($urandom_range(0, 115));
      if ($urandom_range(0, 9) == 0) Field1 = 7'($urandom_range(0, 115));
      if ($urandom_range(0, 9) == 0) Field2 = 7'($urandom_range(0, 115));
      if ($urandom_range(0, 9) == 0) Field3 = 7'($urandom_range(0, 115));
      if ($urandom_range(0, 19) == 0) Blink_mask = 4'($urandom);
      if ($urandom_range(0, 599) == 0) begin
        #2 Reset_n = 1'b0;
        #2 Reset_n = 1'b1;
      end
    end

    @(negedge Clk);
    chk_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
